accumulator_datapath: RTL and testbench

//  Datapath consuming sequence-controller strobes: PC, IR, accumulator (AC), ALU, zero flag, address mux.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/accumulator_alu.sv | 39 +++
 rtl/accumulator_datapath.sv | 189 ++++++++++++++++++
 tb/tb_accumulator_datapath.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the accumulator CPU: the sequence controller and
//   the accumulator datapath both import this package so that opcode values
//   and phase width are defined in exactly one place.
//
//   Contents:
//     PHASE_W   width of the 8-step instruction phase counter
//     OPCODE_W  width of the opcode field at the top of each instruction
//     opcode_t  opcode field type
//     HLT..JMP  opcode values
//     is_alu_op helper: opcodes whose result is written into AC
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PHASE_W  = 3;
    localparam int OPCODE_W = 3;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t HLT = 3'b000;
    localparam opcode_t SKZ = 3'b001;
    localparam opcode_t ADD = 3'b010;
    localparam opcode_t AND = 3'b011;
    localparam opcode_t XOR = 3'b100;
    localparam opcode_t LDA = 3'b101;
    localparam opcode_t STO = 3'b110;
    localparam opcode_t JMP = 3'b111;

    // True for the four opcodes that read an operand and load AC.
    function automatic logic is_alu_op(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage : cpu_pkg

// File: rtl/accumulator_alu.sv
// ---------------------------------------------------------------------------
// accumulator_alu
//   Purely combinational ALU for the accumulator datapath. The operation is
//   selected by the opcode currently held in IR; the second operand is the
//   word read from memory at the instruction's operand address.
//
//   Parameters:
//     DATA_W   accumulator / memory word width
//   Ports:
//     opcode   in   OPCODE_W  opcode field of IR
//     ac       in   DATA_W    current accumulator value
//     d        in   DATA_W    memory read data
//     alu_out  out  DATA_W    value AC will take if loaded this cycle
// ---------------------------------------------------------------------------
module accumulator_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_t           opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] alu_out
);

    always_comb begin
        // NOTE: assigning a default before the case gives every path a value,
        // so no latch is inferred for opcodes that leave AC unchanged.
        alu_out = ac;
        case (opcode)
            ADD:     alu_out = ac + d;   // carry out is intentionally dropped
            AND:     alu_out = ac & d;
            XOR:     alu_out = ac ^ d;
            LDA:     alu_out = d;
            default: alu_out = ac;       // HLT, SKZ, STO, JMP keep AC
        endcase
    end

endmodule : accumulator_alu

// File: rtl/accumulator_datapath.sv
// ---------------------------------------------------------------------------
// accumulator_datapath
//   Register and steering half of the accumulator CPU. It obeys the strobes
//   issued by the sequence controller, holds PC, IR and AC, computes the ALU
//   result, and returns opcode and zero to the controller. The external
//   program/data memory is read asynchronously from mem_addr.
//
//   A local 3-bit phase counter mirrors the controller's 8-step instruction
//   cycle. It is used only to choose the memory address: PC during the fetch
//   half (phases 0-3), IR operand during the execute half (phases 4-7).
//
//   Parameters:
//     DATA_W  memory word / AC width; instruction = {opcode[2:0], operand}
//     ADDR_W  PC / operand width; must not exceed DATA_W-3
//
//   Ports:
//     clk          in   1       rising-edge clock
//     reset        in   1       asynchronous, active-low
//     mem_rd       in   1       controller read strobe (forwarded as mem_re)
//     load_ir      in   1       capture mem_rdata into IR
//     halt         in   1       controller halt request
//     inc_pc       in   1       PC increment
//     load_ac      in   1       AC load from ALU (first cycle of pulse only)
//     load_pc      in   1       PC <= IR operand (wins over inc_pc)
//     mem_rw       in   1       controller write strobe
//     mem_rdata    in   DATA_W  memory read data
//     mem_addr     out  ADDR_W  PC in phases 0-3, IR operand in phases 4-7
//     mem_wdata    out  DATA_W  accumulator value
//     mem_we       out  1       mem_rw gated by halted
//     mem_re       out  1       mem_rd gated by halted
//     opcode       out  3       IR opcode field
//     zero         out  1       AC == 0
//     instr_count  out  16      (INSTR_COUNT_EN only) instructions fetched
//     halted       out  1       sticky halt status, cleared only by reset
//
//   Build option:
//     INSTR_COUNT_EN  when defined, adds the instr_count output and counter.
// ---------------------------------------------------------------------------
module accumulator_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              load_ir,
    input  logic              halt,
    input  logic              inc_pc,
    input  logic              load_ac,
    input  logic              load_pc,
    input  logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        opcode,
    output logic              zero,
`ifdef INSTR_COUNT_EN
    output logic [15:0]       instr_count,
`endif
    output logic              halted
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  ir;
    logic [DATA_W-1:0]  ac;
    logic [PHASE_W-1:0] phase;
    logic               load_ac_q;

    // -----------------------------------------------------------------------
    // Decoded IR fields and ALU
    // -----------------------------------------------------------------------
    opcode_t           ir_opcode;
    logic [ADDR_W-1:0] ir_operand;
    logic [DATA_W-1:0] alu_out;
    logic              ac_load_en;

    assign ir_opcode  = ir[DATA_W-1 -: OPCODE_W];
    assign ir_operand = ir[ADDR_W-1:0];

    accumulator_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode  (ir_opcode),
        .ac      (ac),
        .d       (mem_rdata),
        .alu_out (alu_out)
    );

    // The controller holds load_ac across ALU_OP and STORE. Loading on both
    // cycles would apply ADD twice, so only the rising edge of the strobe
    // commits the ALU result.
    assign ac_load_en = load_ac && !load_ac_q && !halted;

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so that all
    // updates in a cycle see pre-edge values (e.g. the ALU uses the old
    // opcode when load_ir and load_ac coincide).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted    <= 1'b0;
            load_ac_q <= 1'b0;
        end else begin
            load_ac_q <= load_ac;
            if (halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Phase mirrors the controller; it wraps 7 -> 0 and stops while halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (!halted) begin
            phase <= phase + PHASE_W'(1);
        end
    end

    // The controller strobes load_ir on two consecutive phases; both
    // captures see the same memory word, so the second is harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (load_ir && !halted) begin
            ir <= mem_rdata;
        end
    end

    // load_pc beats inc_pc: in the JMP store phase both are high and the
    // jump target must not be incremented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (!halted) begin
            if (load_pc) begin
                pc <= ir_operand;
            end else if (inc_pc) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac <= '0;
        end else if (ac_load_en) begin
            ac <= alu_out;
        end
    end

`ifdef INSTR_COUNT_EN
    // Counts the first cycle of each load_ir pulse, i.e. one per fetch.
    logic load_ir_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ir_q   <= 1'b0;
            instr_count <= '0;
        end else begin
            load_ir_q <= load_ir;
            if (load_ir && !load_ir_q && !halted) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Phase MSB separates the fetch half (PC) from the execute half (operand).
    assign mem_addr  = phase[PHASE_W-1] ? ir_operand : pc;
    assign mem_wdata = ac;
    assign mem_we    = mem_rw && !halted;
    assign mem_re    = mem_rd && !halted;
    assign opcode    = ir_opcode;
    // Combinational so SKZ in ALU_OP sees AC from the previous instruction.
    assign zero      = (ac == '0);

endmodule : accumulator_datapath

// File: tb/tb_accumulator_datapath.sv
// ---------------------------------------------------------------------------
// tb_accumulator_datapath
//   Self-checking bench. It plays the sequence controller (8-phase strobe
//   pattern per opcode), models the memory, and predicts results with an
//   instruction-level model of the ISA (fetch, PC+1, execute). A directed
//   program covers LDA/ADD wrap, JMP priority, SKZ both ways, STO, PC wrap,
//   HLT freeze and mid-instruction reset; random programs follow.
//   Build option INSTR_COUNT_EN adds instr_count checks.
// ---------------------------------------------------------------------------
module tb_accumulator_datapath;
    import cpu_pkg::*;

    typedef struct packed {
        logic rd;
        logic ir;
        logic hlt;
        logic inc;
        logic lac;
        logic lpc;
        logic rw;
    } strobe_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       mem_rd  = 1'b0;
    logic       load_ir = 1'b0;
    logic       halt    = 1'b0;
    logic       inc_pc  = 1'b0;
    logic       load_ac = 1'b0;
    logic       load_pc = 1'b0;
    logic       mem_rw  = 1'b0;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [2:0] opcode;
    logic       zero;
    logic       halted;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    // Memory seen by the DUT, and the ISA model's own copy.
    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];

    // Instruction-level reference state.
    logic [4:0] ref_pc;
    logic [4:0] ref_opnd;
    logic [7:0] ref_ac;
    logic [2:0] ref_op;
    logic       ref_halted;
    int         ref_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    accumulator_datapath #(
        .DATA_W (8),
        .ADDR_W (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .load_ir     (load_ir),
        .halt        (halt),
        .inc_pc      (inc_pc),
        .load_ac     (load_ac),
        .load_pc     (load_pc),
        .mem_rw      (mem_rw),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .opcode      (opcode),
        .zero        (zero),
`ifdef INSTR_COUNT_EN
        .instr_count (instr_count),
`endif
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input strobe_t s);
        mem_rd  = s.rd;
        load_ir = s.ir;
        halt    = s.hlt;
        inc_pc  = s.inc;
        load_ac = s.lac;
        load_pc = s.lpc;
        mem_rw  = s.rw;
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Called just after a falling edge: apply strobes, check the
    // combinational outputs, then let one rising edge pass. A write seen
    // on mem_we is applied to the memory once the edge has gone by.
    task automatic cycle(input strobe_t s, input logic [4:0] exp_addr,
                         input logic exp_we, input logic exp_re);
        logic       we;
        logic [4:0] a;
        logic [7:0] wd;
        drive(s);
        #1;
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_we",   32'(mem_we),   32'(exp_we));
        check("mem_re",   32'(mem_re),   32'(exp_re));
        we = mem_we;
        a  = mem_addr;
        wd = mem_wdata;
        @(negedge clk);
        if (we) mem[a] = wd;
    endtask

    task automatic state_check();
        drive('0);
        #1;
        check("pc_addr", 32'(mem_addr), 32'(ref_halted ? ref_opnd : ref_pc));
        check("ac",      32'(mem_wdata), 32'(ref_ac));
        check("zero",    32'(zero),      32'(ref_ac == 8'h00));
        check("opcode",  32'(opcode),    32'(ref_op));
        check("halted",  32'(halted),    32'(ref_halted));
`ifdef INSTR_COUNT_EN
        check("instr_count", 32'(instr_count), 32'(16'(ref_count)));
`endif
    endtask

    // Assert reset just after a falling edge, check the async clear before
    // any clock edge, then release on a later falling edge (phase 0).
    task automatic do_reset();
        drive('0);
        reset = 1'b0;
        #1;
        check("rst_mem_addr", 32'(mem_addr),  32'(0));
        check("rst_wdata",    32'(mem_wdata), 32'(0));
        check("rst_opcode",   32'(opcode),    32'(0));
        check("rst_zero",     32'(zero),      32'(1));
        check("rst_mem_we",   32'(mem_we),    32'(0));
        check("rst_mem_re",   32'(mem_re),    32'(0));
        check("rst_halted",   32'(halted),    32'(0));
`ifdef INSTR_COUNT_EN
        check("rst_count",    32'(instr_count), 32'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b1;
        ref_pc     = '0;
        ref_opnd   = '0;
        ref_ac     = '0;
        ref_op     = HLT;
        ref_halted = 1'b0;
        ref_count  = 0;
    endtask

    // Play one instruction as the controller would. n_ph < 8 stops early
    // (used before a mid-instruction reset; the model is then not updated).
    task automatic run_instr(input int n_ph);
        logic [7:0] instr;
        logic [7:0] d;
        logic [2:0] op;
        logic [4:0] opnd;
        logic [4:0] pc0;
        logic       alu;
        logic       z;
        strobe_t    s;
        pc0   = ref_pc;
        instr = ref_mem[pc0];
        op    = instr[7:5];
        opnd  = instr[4:0];
        alu   = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        z     = (ref_ac == 8'h00);
        for (int p = 0; p < 8; p++) begin
            if (p >= n_ph) return;
            if (op == HLT && p == 5) break;
            s = '0;
            case (p)
                1: s.rd = 1'b1;
                2, 3: begin s.rd = 1'b1; s.ir = 1'b1; end
                4: begin s.inc = 1'b1; s.hlt = (op == HLT); end
                5: s.rd = alu;
                6: begin
                    s.rd  = alu;
                    s.lac = alu;
                    s.inc = (op == SKZ) && z;
                    s.lpc = (op == JMP);
                end
                7: begin
                    s.rd  = alu;
                    s.lac = alu;
                    s.inc = (op == JMP);
                    s.lpc = (op == JMP);
                    s.rw  = (op == STO);
                end
                default: ;
            endcase
            cycle(s, (p < 4) ? pc0 : opnd, s.rw, s.rd);
        end
        // ISA semantics.
        ref_count++;
        ref_pc = pc0 + 5'd1;
        d      = ref_mem[opnd];
        case (op)
            HLT: ref_halted = 1'b1;
            SKZ: if (ref_ac == 8'h00) ref_pc = ref_pc + 5'd1;
            ADD: ref_ac = ref_ac + d;
            AND: ref_ac = ref_ac & d;
            XOR: ref_ac = ref_ac ^ d;
            LDA: ref_ac = d;
            STO: ref_mem[opnd] = ref_ac;
            JMP: ref_pc = opnd;
            default: ;
        endcase
        ref_op   = op;
        ref_opnd = opnd;
        state_check();
    endtask

    // 20 cycles of random strobes while halted: nothing may move.
    task automatic halted_soak();
        for (int i = 0; i < 20; i++) begin
            cycle(strobe_t'(7'($urandom)), ref_opnd, 1'b0, 1'b0);
        end
        state_check();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) poke(i, 8'h00);
        @(negedge clk);
        do_reset();

        // Directed program.
        poke(5'h00, 8'hA5);  // LDA 5
        poke(5'h01, 8'h46);  // ADD 6
        poke(5'h02, 8'hFA);  // JMP 1A
        poke(5'h05, 8'h0F);
        poke(5'h06, 8'hF3);
        poke(5'h07, 8'h00);
        poke(5'h09, 8'hA5);
        poke(5'h1A, 8'h67);  // AND 7  -> AC = 0
        poke(5'h1B, 8'h20);  // SKZ    -> skips 1C
        poke(5'h1C, 8'hA6);  // skipped
        poke(5'h1D, 8'hA9);  // LDA 9  -> AC = A5
        poke(5'h1E, 8'h20);  // SKZ    -> no skip
        poke(5'h1F, 8'hC3);  // STO 3, PC wraps to 0

        run_instr(8);
        check("lda_ac", 32'(mem_wdata), 32'(8'h0F));
        run_instr(8);
        check("add_wrap_ac", 32'(mem_wdata), 32'(8'h02));
        check("add_zero",    32'(zero),      32'(0));
        run_instr(8);
        check("jmp_pc", 32'(mem_addr), 32'(5'h1A));
        run_instr(8);
        check("and_zero", 32'(zero), 32'(1));
        run_instr(8);
        check("skz_taken_pc", 32'(mem_addr), 32'(5'h1D));
        run_instr(8);
        run_instr(8);
        check("skz_not_taken_pc", 32'(mem_addr), 32'(5'h1F));
        run_instr(8);
        check("pc_wrap", 32'(mem_addr), 32'(5'h00));
        check("sto_mem", 32'(mem[3]),   32'(8'hA5));

        poke(5'h00, 8'h07);  // HLT (operand 7)
        run_instr(8);
        check("hlt_halted", 32'(halted), 32'(1));
        halted_soak();

        // Reset in the middle of an instruction, after AC has changed.
        do_reset();
        poke(5'h00, 8'hA5);  // LDA 5
        poke(5'h01, 8'h46);  // ADD 6
        run_instr(8);
        run_instr(7);
        do_reset();
        state_check();

        // Random programs.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                logic [7:0] w;
                w = 8'($urandom);
                if (w[7:5] == HLT) w[7:5] = 3'($urandom_range(1, 7));
                if ($urandom_range(0, 5) == 0) w[4:0] = 5'h00;
                poke(i, w);
            end
            do_reset();
            for (int n = 0; n < 60 && !ref_halted; n++) run_instr(8);
            if (!ref_halted) begin
                poke(int'(ref_pc), {HLT, 5'($urandom)});
                run_instr(8);
            end
            halted_soak();
            for (int i = 0; i < 32; i++) begin
                check("mem_image", 32'(mem[i]), 32'(ref_mem[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_accumulator_datapath
